// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage sitting directly after the program counter. On fetch_req it
//   reads the word at the current PC from instruction memory, latches it into
//   the instruction register, pulses pc_incr once and waits for the PC's
//   reg_wr_ack before signalling completion with a one-cycle instr_valid.
//
//   Optional feature macro: FETCH_TIMEOUT_EN
//     defined   -> REQ is abandoned after PA_TO cycles without mem_ack and the
//                  sticky fetch_err flag is raised.
//     undefined -> REQ waits indefinitely, fetch_err is tied to 0.
//
// Ports
//   clk, rst_b    clock (rising edge), asynchronous active-low reset
//   fetch_req     start one fetch, sampled only in IDLE
//   pc_value      current PC word address
//   pc_wr_ack     PC has finished the increment
//   pc_incr       one-cycle increment pulse to the PC
//   mem_addr      instruction memory address, stable for the whole fetch
//   mem_rd        read strobe, held until mem_ack
//   mem_data      read data, valid with mem_ack
//   mem_ack       read complete
//   instr         instruction register
//   instr_valid   one-cycle pulse, fetch finished and instr stable
//   busy          high in every state except IDLE
//   fetch_err     sticky memory timeout flag
// ---------------------------------------------------------------------------
module instruction_fetch #(
   parameter int PA_DATA = 32,
   parameter int PA_TO   = 16
) (
   input  logic               clk,
   input  logic               rst_b,
   input  logic               fetch_req,
   input  logic [PA_DATA-1:0] pc_value,
   input  logic               pc_wr_ack,
   output logic               pc_incr,
   output logic [PA_DATA-1:0] mem_addr,
   output logic               mem_rd,
   input  logic [PA_DATA-1:0] mem_data,
   input  logic               mem_ack,
   output logic [PA_DATA-1:0] instr,
   output logic               instr_valid,
   output logic               busy,
   output logic               fetch_err
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_INCR = 3'd2,
      S_WAIT = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [PA_DATA-1:0] mem_addr_q, mem_addr_d;
   logic [PA_DATA-1:0] instr_q, instr_d;
   logic               mem_rd_q, mem_rd_d;
   logic               pc_incr_q, pc_incr_d;
   logic               instr_valid_q, instr_valid_d;
   logic               busy_q, busy_d;

`ifdef FETCH_TIMEOUT_EN
   localparam int             TW      = $clog2(PA_TO + 1);
   localparam logic [TW-1:0]  TO_LAST = TW'(PA_TO - 1);
   logic [TW-1:0]             timer_q, timer_d;
   logic                      fetch_err_q, fetch_err_d;
`endif

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q       <= S_IDLE;
         mem_addr_q    <= '0;
         instr_q       <= '0;
         mem_rd_q      <= 1'b0;
         pc_incr_q     <= 1'b0;
         instr_valid_q <= 1'b0;
         busy_q        <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         timer_q       <= '0;
         fetch_err_q   <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         mem_addr_q    <= mem_addr_d;
         instr_q       <= instr_d;
         mem_rd_q      <= mem_rd_d;
         pc_incr_q     <= pc_incr_d;
         instr_valid_q <= instr_valid_d;
         busy_q        <= busy_d;
`ifdef FETCH_TIMEOUT_EN
         timer_q       <= timer_d;
         fetch_err_q   <= fetch_err_d;
`endif
      end
   end

   always_comb begin
      state_d       = state_q;
      mem_addr_d    = mem_addr_q;
      instr_d       = instr_q;
      mem_rd_d      = mem_rd_q;
      pc_incr_d     = 1'b0;
      instr_valid_d = 1'b0;
      busy_d        = busy_q;
`ifdef FETCH_TIMEOUT_EN
      timer_d       = timer_q;
      fetch_err_d   = fetch_err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (fetch_req) begin
               state_d    = S_REQ;
               mem_addr_d = pc_value;
               mem_rd_d   = 1'b1;
               busy_d     = 1'b1;
`ifdef FETCH_TIMEOUT_EN
               timer_d     = '0;
               fetch_err_d = 1'b0;
`endif
            end
         end
         S_REQ: begin
            // An acknowledge arriving in the last timeout cycle still wins.
            if (mem_ack) begin
               instr_d   = mem_data;
               mem_rd_d  = 1'b0;
               pc_incr_d = 1'b1;
               state_d   = S_INCR;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (timer_q == TO_LAST) begin
               mem_rd_d    = 1'b0;
               fetch_err_d = 1'b1;
               state_d     = S_DONE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
`endif
         end
         S_INCR: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (pc_wr_ack) begin
               instr_valid_d = 1'b1;
               state_d       = S_DONE;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            // Illegal encoding: recover to the reset picture in one cycle.
            state_d    = S_IDLE;
            mem_addr_d = '0;
            instr_d    = '0;
            mem_rd_d   = 1'b0;
            busy_d     = 1'b0;
`ifdef FETCH_TIMEOUT_EN
            timer_d     = '0;
            fetch_err_d = 1'b0;
`endif
         end
      endcase
   end

   assign pc_incr     = pc_incr_q;
   assign mem_addr    = mem_addr_q;
   assign mem_rd      = mem_rd_q;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign busy        = busy_q;
`ifdef FETCH_TIMEOUT_EN
   assign fetch_err   = fetch_err_q;
`else
   assign fetch_err   = 1'b0;
`endif

endmodule
